dds_tone_analyzer: RTL and testbench

//  Receive-side counterpart of the DDS sine generator: consumes the 8-bit Magnitude sample stream.

---
 rtl/dds_tone_analyzer_pkg.sv | 36 +++
 rtl/dds_tone_analyzer_if.sv | 24 ++
 rtl/dds_extremum_tracker.sv | 40 ++++
 rtl/dds_tone_analyzer.sv | 124 ++++++++++++
 tb/tb_dds_tone_analyzer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/dds_tone_analyzer_pkg.sv
// Shared definitions for the DDS tone analyzer: widths, thresholds,
// analyzer states and sample classification.
package dds_tone_analyzer_pkg;

    localparam int DATA_W = 8;
    localparam int MID    = 128;
    localparam int HYST   = 4;

    localparam logic [DATA_W-1:0] HI_THR = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_THR = DATA_W'(MID - HYST);

    typedef enum logic [1:0] {
        ST_ACQ  = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CL_BAND = 2'd0,
        CL_HI   = 2'd1,
        CL_LO   = 2'd2
    } cls_e;

    function automatic cls_e classify(input logic [DATA_W-1:0] s);
        cls_e c;
        c = CL_BAND;
        if (s >= HI_THR) begin
            c = CL_HI;
        end else if (s <= LO_THR) begin
            c = CL_LO;
        end
        return c;
    endfunction

endpackage

// File: rtl/dds_tone_analyzer_if.sv
// Sample stream in, measurement results out.
interface dds_tone_analyzer_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic [CNT_W-1:0]  period;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] trough;
    logic              meas_valid;
    logic              locked;
    logic              overflow;

    modport master (
        output sample_valid, sample,
        input  period, peak, trough, meas_valid, locked, overflow
    );

    modport slave (
        input  sample_valid, sample,
        output period, peak, trough, meas_valid, locked, overflow
    );
endinterface

// File: rtl/dds_extremum_tracker.sv
// Running max/min of the sample stream; load restarts both from sample.
module dds_extremum_tracker
    import dds_tone_analyzer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] max_o,
    output logic [DATA_W-1:0] min_o
);
    logic [DATA_W-1:0] max_d, max_q;
    logic [DATA_W-1:0] min_d, min_q;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (load) begin
            max_d = sample;
            min_d = sample;
        end else if (en) begin
            if (sample > max_q) max_d = sample;
            if (sample < min_q) min_d = sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;
endmodule

// File: rtl/dds_tone_analyzer.sv
// Measures samples per cycle between rising mid-scale crossings
// (with hysteresis) and the peak/trough of each completed period.
module dds_tone_analyzer
    import dds_tone_analyzer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    dds_tone_analyzer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            st_d, st_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  period_d, period_q;
    logic [DATA_W-1:0] peak_d, peak_q;
    logic [DATA_W-1:0] trough_d, trough_q;
    logic              meas_d, meas_q;
    logic              locked_d, locked_q;
    logic              ovf_d, ovf_q;
    logic              trk_load, trk_en;
    logic [DATA_W-1:0] trk_max, trk_min;
    cls_e              cls;

    assign cls = classify(bus.sample);

    dds_extremum_tracker u_trk (
        .clk    (clk),
        .rst    (rst),
        .load   (trk_load),
        .en     (trk_en),
        .sample (bus.sample),
        .max_o  (trk_max),
        .min_o  (trk_min)
    );

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        peak_d   = peak_q;
        trough_d = trough_q;
        meas_d   = 1'b0;
        locked_d = locked_q;
        ovf_d    = 1'b0;
        trk_load = 1'b0;
        trk_en   = 1'b0;
        if (clr) begin
            st_d     = ST_ACQ;
            cnt_d    = '0;
            period_d = '0;
            peak_d   = '0;
            trough_d = '0;
            locked_d = 1'b0;
        end else if (bus.sample_valid) begin
            unique case (st_q)
                ST_ACQ: begin
                    if (cls == CL_LO) st_d = ST_ARM;
                end
                ST_ARM: begin
                    if (cls == CL_HI) begin
                        st_d     = ST_HIGH;
                        cnt_d    = '0;
                        trk_load = 1'b1;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    // Saturation aborts before a wrapped period can be latched
                    if (cnt_q == CNT_MAX) begin
                        ovf_d    = 1'b1;
                        locked_d = 1'b0;
                        st_d     = ST_ACQ;
                        cnt_d    = '0;
                    end else if (st_q == ST_LOW && cls == CL_HI) begin
                        period_d = cnt_q + 1'b1;
                        peak_d   = trk_max;
                        trough_d = trk_min;
                        meas_d   = 1'b1;
                        locked_d = 1'b1;
                        cnt_d    = '0;
                        trk_load = 1'b1;
                        st_d     = ST_HIGH;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        trk_en = 1'b1;
                        if (st_q == ST_HIGH && cls == CL_LO) st_d = ST_LOW;
                    end
                end
                default: st_d = ST_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= ST_ACQ;
            cnt_q    <= '0;
            period_q <= '0;
            peak_q   <= '0;
            trough_q <= '0;
            meas_q   <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            meas_q   <= meas_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.peak       = peak_q;
    assign bus.trough     = trough_q;
    assign bus.meas_valid = meas_q;
    assign bus.locked     = locked_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_dds_tone_analyzer.sv
// Directed bench for dds_tone_analyzer: a 16-bit-counter instance for
// the main scenarios and an 8-bit-counter instance for overflow.
module tb_dds_tone_analyzer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    int   mv16   = 0;
    int   mv8    = 0;
    int   base;

    always #5 clk = ~clk;

    dds_tone_analyzer_if #(.DATA_W(8), .CNT_W(16)) b16 ();
    dds_tone_analyzer_if #(.DATA_W(8), .CNT_W(8))  b8 ();

    dds_tone_analyzer #(.CNT_W(16)) dut16 (
        .clk (clk), .rst (rst), .clr (clr), .bus (b16)
    );
    dds_tone_analyzer #(.CNT_W(8)) dut8 (
        .clk (clk), .rst (rst), .clr (clr), .bus (b8)
    );

    always @(negedge clk) begin
        if (b16.meas_valid === 1'b1) mv16++;
        if (b8.meas_valid === 1'b1) mv8++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] s);
        b16.sample_valid = v;
        b16.sample       = s;
        @(posedge clk);
        #1;
        b16.sample_valid = 1'b0;
    endtask

    task automatic step8(input logic v, input logic [7:0] s);
        b8.sample_valid = v;
        b8.sample       = s;
        @(posedge clk);
        #1;
        b8.sample_valid = 1'b0;
    endtask

    function automatic logic [7:0] sine(input int i);
        real r;
        r = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * (i % 256) / 256.0);
        return 8'(int'(r));
    endfunction

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        b16.sample_valid = 1'b0;
        b16.sample       = 8'd0;
        b8.sample_valid  = 1'b0;
        b8.sample        = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // reset state
        chk("rst_period", int'(b16.period), 0);
        chk("rst_peak", int'(b16.peak), 0);
        chk("rst_trough", int'(b16.trough), 0);
        chk("rst_meas", int'(b16.meas_valid), 0);
        chk("rst_locked", int'(b16.locked), 0);
        chk("rst_ovf", int'(b16.overflow), 0);

        // full sine, continuous valid
        base = mv16;
        for (int i = 0; i <= 3 * 256 + 4; i++) step(1'b1, sine(i));
        chk("sine_meas_cnt", mv16 - base, 2);
        chk("sine_period", int'(b16.period), 256);
        chk("sine_peak", int'(b16.peak), 255);
        chk("sine_trough", int'(b16.trough), 1);
        chk("sine_locked", int'(b16.locked), 1);
        chk("sine_meas_low", int'(b16.meas_valid), 0);

        // same sine, valid toggling
        do_clr();
        chk("clr_period", int'(b16.period), 0);
        chk("clr_locked", int'(b16.locked), 0);
        base = mv16;
        for (int i = 0; i <= 3 * 256 + 4; i++) begin
            step(1'b1, sine(i));
            step(1'b0, sine(i));
        end
        chk("tog_meas_cnt", mv16 - base, 2);
        chk("tog_period", int'(b16.period), 256);
        chk("tog_peak", int'(b16.peak), 255);
        chk("tog_trough", int'(b16.trough), 1);

        // hysteresis noise near mid-scale
        do_clr();
        base = mv16;
        step(1'b1, 8'd100);
        step(1'b1, 8'd131);
        step(1'b1, 8'd126);
        step(1'b1, 8'd131);
        step(1'b1, 8'd126);
        step(1'b1, 8'd140);
        chk("hyst_no_meas", mv16 - base, 0);
        step(1'b1, 8'd100);
        step(1'b1, 8'd126);
        step(1'b1, 8'd131);
        chk("hyst_131_band", mv16 - base, 0);
        step(1'b1, 8'd132);
        chk("hyst_meas", int'(b16.meas_valid), 1);
        chk("hyst_period", int'(b16.period), 4);
        chk("hyst_peak", int'(b16.peak), 140);
        chk("hyst_trough", int'(b16.trough), 100);
        chk("hyst_locked", int'(b16.locked), 1);

        // reset while in LOW
        step(1'b1, 8'd100);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mrst_period", int'(b16.period), 0);
        chk("mrst_peak", int'(b16.peak), 0);
        chk("mrst_trough", int'(b16.trough), 0);
        chk("mrst_locked", int'(b16.locked), 0);
        base = mv16;
        step(1'b1, 8'd200);
        step(1'b1, 8'd200);
        step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        chk("mrst_rearm", mv16 - base, 0);
        step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        chk("mrst_meas", int'(b16.meas_valid), 1);
        chk("mrst_period2", int'(b16.period), 2);
        chk("mrst_peak2", int'(b16.peak), 200);
        chk("mrst_trough2", int'(b16.trough), 100);

        // clr together with a crossing sample
        step(1'b1, 8'd100);
        base = mv16;
        clr = 1'b1;
        step(1'b1, 8'd200);
        clr = 1'b0;
        chk("clr_x_meas", int'(b16.meas_valid), 0);
        chk("clr_x_period", int'(b16.period), 0);
        chk("clr_x_peak", int'(b16.peak), 0);
        chk("clr_x_trough", int'(b16.trough), 0);
        chk("clr_x_locked", int'(b16.locked), 0);
        step(1'b1, 8'd100);
        step(1'b1, 8'd200);
        chk("clr_x_acq", mv16 - base, 0);

        // overflow on the 8-bit counter instance
        step8(1'b1, 8'd100);
        step8(1'b1, 8'd200);
        step8(1'b1, 8'd100);
        step8(1'b1, 8'd200);
        chk("ovf_pre_period", int'(b8.period), 2);
        chk("ovf_pre_locked", int'(b8.locked), 1);
        for (int i = 0; i < 255; i++) step8(1'b1, 8'd100);
        chk("ovf_not_yet", int'(b8.overflow), 0);
        chk("ovf_still_locked", int'(b8.locked), 1);
        step8(1'b1, 8'd100);
        chk("ovf_pulse", int'(b8.overflow), 1);
        chk("ovf_unlocked", int'(b8.locked), 0);
        chk("ovf_period_kept", int'(b8.period), 2);
        chk("ovf_peak_kept", int'(b8.peak), 200);
        chk("ovf_trough_kept", int'(b8.trough), 100);
        base = mv8;
        step8(1'b0, 8'd100);
        chk("ovf_pulse_end", int'(b8.overflow), 0);
        step8(1'b1, 8'd200);
        step8(1'b1, 8'd200);
        chk("ovf_acq", mv8 - base, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
